// File: rtl/pattern_pkg.sv
// Shared mode encoding and colour constants for the 480p test-pattern datapath.
package pattern_pkg;

    localparam int COLOUR_BITS = 4;

    typedef enum logic [1:0] {
        MODE_SOLID  = 2'd0,
        MODE_SQUARE = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BARS   = 2'd3
    } mode_t;

    typedef struct packed {
        logic [COLOUR_BITS-1:0] r;
        logic [COLOUR_BITS-1:0] g;
        logic [COLOUR_BITS-1:0] b;
    } rgb_t;

    localparam rgb_t BLACK     = '{r: 4'h0, g: 4'h0, b: 4'h0};
    localparam rgb_t BG_COLOUR = '{r: 4'h1, g: 4'h3, b: 4'h7};
    localparam rgb_t SQ_COLOUR = '{r: 4'hF, g: 4'hF, b: 4'hF};

    // Left-to-right bar colours; the last bar is grey so it stays distinct from blanking.
    localparam rgb_t BAR_LUT [8] = '{
        '{4'hF, 4'hF, 4'hF},
        '{4'hF, 4'hF, 4'h0},
        '{4'h0, 4'hF, 4'hF},
        '{4'h0, 4'hF, 4'h0},
        '{4'hF, 4'h0, 4'hF},
        '{4'hF, 4'h0, 4'h0},
        '{4'h0, 4'h0, 4'hF},
        '{4'h8, 4'h8, 4'h8}
    };

endpackage

// File: rtl/square_mover.sv
// Bouncing-square position and velocity; steps once per frame tick while enabled.
module square_mover
    import pattern_pkg::*;
#(
    parameter int COORD_BITS = 10,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int SQ_SIZE    = 200,
    parameter int SQ_X0      = 221,
    parameter int SQ_Y0      = 141,
    parameter int SPEED      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  enable,
    output logic [COORD_BITS-1:0] sq_x,
    output logic [COORD_BITS-1:0] sq_y
);

    localparam int W = COORD_BITS + 1;
    localparam logic signed [W-1:0] STEP  = W'(SPEED);
    localparam logic signed [W-1:0] MAX_X = W'(H_ACTIVE - SQ_SIZE);
    localparam logic signed [W-1:0] MAX_Y = W'(V_ACTIVE - SQ_SIZE);

    logic signed [W-1:0] dx, dy, nx, ny;

    always_comb begin
        nx = $signed({1'b0, sq_x}) + dx;
        ny = $signed({1'b0, sq_y}) + dy;
    end

    // Each axis clamps to its wall and reverses independently, so corners flip both.
    always_ff @(posedge clk) begin
        if (reset) begin
            sq_x <= COORD_BITS'(SQ_X0);
            sq_y <= COORD_BITS'(SQ_Y0);
            dx   <= STEP;
            dy   <= STEP;
        end else if (tick && enable) begin
            if (nx < 0) begin
                sq_x <= '0;
                dx   <= STEP;
            end else if (nx > MAX_X) begin
                sq_x <= MAX_X[COORD_BITS-1:0];
                dx   <= -STEP;
            end else begin
                sq_x <= nx[COORD_BITS-1:0];
            end

            if (ny < 0) begin
                sq_y <= '0;
                dy   <= STEP;
            end else if (ny > MAX_Y) begin
                sq_y <= MAX_Y[COORD_BITS-1:0];
                dy   <= -STEP;
            end else begin
                sq_y <= ny[COORD_BITS-1:0];
            end
        end
    end

endmodule

// File: rtl/pattern_sequencer.sv
// Frame-synchronous pattern selector and pixel generator between the 480p timing
// generator and the TMDS encoders; mode and square position only change at the frame tick.
module pattern_sequencer
    import pattern_pkg::*;
#(
    parameter int COORD_BITS  = 10,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SQ_SIZE     = 200,
    parameter int SQ_X0       = 221,
    parameter int SQ_Y0       = 141,
    parameter int SPEED       = 2,
    parameter int AUTO_FRAMES = 120
) (
    input  logic                   i_clk_pxl,
    input  logic                   i_reset,
    input  logic [COORD_BITS-1:0]  i_sx,
    input  logic [COORD_BITS-1:0]  i_sy,
    input  logic                   i_hsync,
    input  logic                   i_vsync,
    input  logic                   i_de,
    input  logic                   i_next_mode,
    input  logic                   i_auto,
    output logic [COLOUR_BITS-1:0] o_r,
    output logic [COLOUR_BITS-1:0] o_g,
    output logic [COLOUR_BITS-1:0] o_b,
    output logic                   o_hsync,
    output logic                   o_vsync,
    output logic                   o_de,
    output logic [1:0]             o_mode
);

    localparam int FC_BITS = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
    localparam logic [FC_BITS-1:0] FC_LAST = FC_BITS'(AUTO_FRAMES - 1);
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int CW    = COORD_BITS + 1;

    mode_t                 mode, next_mode;
    logic                  tick, pend, auto_due, advance;
    logic [FC_BITS-1:0]    frame_cnt;
    logic [COORD_BITS-1:0] sq_x, sq_y;
    logic [CW-1:0]         box_x, box_y, px, py;
    logic                  in_square;
    logic [2:0]            bar_idx;
    rgb_t                  pix;

    assign tick     = (i_sx == '0) && (i_sy == COORD_BITS'(V_ACTIVE));
    assign auto_due = i_auto && (frame_cnt == FC_LAST);
    assign advance  = tick && (pend || i_next_mode || auto_due);
    assign o_mode   = mode;

    // A request latched mid-frame is held until the tick; pulses in between collapse.
    always_ff @(posedge i_clk_pxl) begin
        if (i_reset) begin
            pend      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (tick)
                pend <= 1'b0;
            else if (i_next_mode)
                pend <= 1'b1;

            if (!i_auto || advance)
                frame_cnt <= '0;
            else if (tick)
                frame_cnt <= frame_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk_pxl) begin
        if (i_reset)
            mode <= MODE_SOLID;
        else
            mode <= next_mode;
    end

    always_comb begin
        next_mode = mode;
        if (advance) begin
            unique case (mode)
                MODE_SOLID:  next_mode = MODE_SQUARE;
                MODE_SQUARE: next_mode = MODE_BOUNCE;
                MODE_BOUNCE: next_mode = MODE_BARS;
                MODE_BARS:   next_mode = MODE_SOLID;
                default:     next_mode = MODE_SOLID;
            endcase
        end
    end

    square_mover #(
        .COORD_BITS (COORD_BITS),
        .H_ACTIVE   (H_ACTIVE),
        .V_ACTIVE   (V_ACTIVE),
        .SQ_SIZE    (SQ_SIZE),
        .SQ_X0      (SQ_X0),
        .SQ_Y0      (SQ_Y0),
        .SPEED      (SPEED)
    ) u_mover (
        .clk    (i_clk_pxl),
        .reset  (i_reset),
        .tick   (tick),
        .enable (mode == MODE_BOUNCE),
        .sq_x   (sq_x),
        .sq_y   (sq_y)
    );

    // Widened by one bit so x+SQ_SIZE cannot wrap near the right edge.
    always_comb begin
        px        = {1'b0, i_sx};
        py        = {1'b0, i_sy};
        box_x     = (mode == MODE_BOUNCE) ? {1'b0, sq_x} : CW'(SQ_X0);
        box_y     = (mode == MODE_BOUNCE) ? {1'b0, sq_y} : CW'(SQ_Y0);
        in_square = (px >= box_x) && (px < box_x + CW'(SQ_SIZE)) &&
                    (py >= box_y) && (py < box_y + CW'(SQ_SIZE));
    end

    // Bar index by threshold compare against multiples of the bar width.
    always_comb begin
        bar_idx = '0;
        for (int k = 1; k < 8; k++) begin
            if (32'(i_sx) >= 32'(k * BAR_W))
                bar_idx = 3'(k);
        end
    end

    always_comb begin
        pix = BG_COLOUR;
        unique case (mode)
            MODE_SOLID:  pix = BG_COLOUR;
            MODE_SQUARE,
            MODE_BOUNCE: pix = in_square ? SQ_COLOUR : BG_COLOUR;
            MODE_BARS:   pix = BAR_LUT[bar_idx];
            default:     pix = BG_COLOUR;
        endcase
        if (!i_de)
            pix = BLACK;
    end

    always_ff @(posedge i_clk_pxl) begin
        if (i_reset) begin
            o_r     <= '0;
            o_g     <= '0;
            o_b     <= '0;
            o_hsync <= 1'b0;
            o_vsync <= 1'b0;
            o_de    <= 1'b0;
        end else begin
            o_r     <= pix.r;
            o_g     <= pix.g;
            o_b     <= pix.b;
            o_hsync <= i_hsync;
            o_vsync <= i_vsync;
            o_de    <= i_de;
        end
    end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Self-checking bench for pattern_sequencer: compressed frames driven directly on sx/sy,
// compared cycle by cycle against a frame-level reference model.
module tb_pattern_sequencer;

    localparam int AF    = 3;
    localparam int SQ    = 200;
    localparam int X0    = 221;
    localparam int Y0    = 141;
    localparam int MAX_X = 640 - SQ;
    localparam int MAX_Y = 480 - SQ;
    localparam int STEP  = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic [9:0] sx, sy;
    logic       hsync, vsync, de, next_mode, auto_mode;
    logic [3:0] r, g, b;
    logic       o_hsync, o_vsync, o_de;
    logic [1:0] mode_out;

    always #20 clock = ~clock;

    pattern_sequencer #(.AUTO_FRAMES(AF)) dut (
        .i_clk_pxl   (clock),
        .i_reset     (reset),
        .i_sx        (sx),
        .i_sy        (sy),
        .i_hsync     (hsync),
        .i_vsync     (vsync),
        .i_de        (de),
        .i_next_mode (next_mode),
        .i_auto      (auto_mode),
        .o_r         (r),
        .o_g         (g),
        .o_b         (b),
        .o_hsync     (o_hsync),
        .o_vsync     (o_vsync),
        .o_de        (o_de),
        .o_mode      (mode_out)
    );

    int compared   = 0;
    int mismatched = 0;

    int m_mode, m_cnt, m_x, m_y, m_dx, m_dy;
    bit m_pend;

    logic [11:0] exp_rgb;
    logic [2:0]  exp_sync;
    logic [1:0]  exp_mode;

    function automatic logic [11:0] barColour(input int idx);
        case (idx)
            0:       return 12'hFFF;
            1:       return 12'hFF0;
            2:       return 12'h0FF;
            3:       return 12'h0F0;
            4:       return 12'hF0F;
            5:       return 12'hF00;
            6:       return 12'h00F;
            default: return 12'h888;
        endcase
    endfunction

    function automatic logic [11:0] colourAt(input int px, input int py, input bit pde);
        int bx, by, idx;
        if (!pde) return 12'h000;
        case (m_mode)
            0: return 12'h137;
            1, 2: begin
                bx = (m_mode == 2) ? m_x : X0;
                by = (m_mode == 2) ? m_y : Y0;
                if (px >= bx && px < bx + SQ && py >= by && py < by + SQ) return 12'hFFF;
                return 12'h137;
            end
            default: begin
                idx = px / 80;
                if (idx > 7) idx = 7;
                return barColour(idx);
            end
        endcase
    endfunction

    task automatic modelReset();
        m_mode = 0; m_pend = 0; m_cnt = 0;
        m_x = X0; m_y = Y0; m_dx = STEP; m_dy = STEP;
    endtask

    // Square slides by its velocity and bounces off whichever walls it would cross.
    task automatic modelMove();
        int nx, ny;
        nx = m_x + m_dx;
        ny = m_y + m_dy;
        if (nx < 0) begin m_x = 0; m_dx = STEP; end
        else if (nx > MAX_X) begin m_x = MAX_X; m_dx = -STEP; end
        else m_x = nx;
        if (ny < 0) begin m_y = 0; m_dy = STEP; end
        else if (ny > MAX_Y) begin m_y = MAX_Y; m_dy = -STEP; end
        else m_y = ny;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One pixel clock: drive inputs, advance the model, then check all outputs after the edge.
    task automatic applyStimulus(input bit rst, input int px, input int py, input bit pde, input bit pnm);
        bit tick, adv;
        @(negedge clock);
        reset     = rst;
        sx        = 10'(px);
        sy        = 10'(py);
        de        = pde;
        hsync     = 1'($urandom_range(1, 0));
        vsync     = 1'($urandom_range(1, 0));
        next_mode = pnm;
        if (rst) begin
            exp_rgb  = 12'h000;
            exp_sync = 3'b000;
            modelReset();
        end else begin
            exp_rgb  = colourAt(px, py, pde);
            exp_sync = {hsync, vsync, pde};
            tick     = (px == 0 && py == 480);
            if (tick) begin
                if (m_mode == 2) modelMove();
                adv = m_pend || pnm || (auto_mode && m_cnt == AF - 1);
                if (adv) begin
                    m_mode = (m_mode + 1) % 4;
                    m_cnt  = 0;
                end else if (auto_mode) begin
                    m_cnt++;
                end
                m_pend = 0;
            end else if (pnm) begin
                m_pend = 1;
            end
            if (!auto_mode) m_cnt = 0;
        end
        exp_mode = 2'(m_mode);
        @(posedge clock);
        #1;
        checkOutput("rgb", {20'h0, r, g, b}, {20'h0, exp_rgb});
        checkOutput("sync_de", {29'h0, o_hsync, o_vsync, o_de}, {29'h0, exp_sync});
        checkOutput("mode", {30'h0, mode_out}, {30'h0, exp_mode});
    endtask

    task automatic pixel(input int px, input int py);
        bit act;
        act = (px < 640) && (py < 480);
        applyStimulus(1'b0, px, py, act && ($urandom_range(7, 0) != 0), 1'b0);
    endtask

    task automatic frameTick(input bit nm);
        applyStimulus(1'b0, 0, 480, 1'b0, nm);
    endtask

    task automatic checkPosition(input string tag);
        checkOutput({tag, "_x"}, 32'(dut.u_mover.sq_x), 32'(m_x));
        checkOutput({tag, "_y"}, 32'(dut.u_mover.sq_y), 32'(m_y));
    endtask

    // A few pixels hugging the square edges, one random active pixel, one blanking pixel, then the tick.
    task automatic runFrame(input bit nm);
        int bx, by, px, py;
        bx = (m_mode == 2) ? m_x : X0;
        by = (m_mode == 2) ? m_y : Y0;
        px = bx + SQ - 1 + int'($urandom_range(1, 0));
        py = by + int'($urandom_range(SQ - 1, 0));
        pixel((px > 639) ? 639 : px, py);
        px = bx - 1 + int'($urandom_range(1, 0));
        py = by - 1 + int'($urandom_range(1, 0));
        pixel((px < 0) ? 0 : px, (py < 0) ? 0 : py);
        pixel(int'($urandom_range(639, 0)), int'($urandom_range(479, 0)));
        pixel(int'($urandom_range(799, 640)), int'($urandom_range(524, 0)));
        frameTick(nm);
    endtask

    initial begin
        reset = 1'b1; sx = '0; sy = '0; hsync = 1'b0; vsync = 1'b0;
        de = 1'b0; next_mode = 1'b0; auto_mode = 1'b0;
        modelReset();

        applyStimulus(1'b1, 10, 10, 1'b1, 1'b0);
        applyStimulus(1'b1, 11, 10, 1'b1, 1'b0);
        checkPosition("pos_after_por");

        // Two requests in one frame collapse into one advance.
        pixel(5, 50);
        applyStimulus(1'b0, 30, 100, 1'b1, 1'b1);
        pixel(40, 150);
        applyStimulus(1'b0, 30, 200, 1'b1, 1'b1);
        pixel(100, 300);
        frameTick(1'b0);
        checkOutput("double_pulse_mode", {30'h0, mode_out}, 32'd1);
        applyStimulus(1'b0, 300, 200, 1'b1, 1'b0);
        checkOutput("square_pixel_300_200", {20'h0, r, g, b}, 32'hFFF);

        frameTick(1'b1);
        checkOutput("tick_pulse_mode", {30'h0, mode_out}, 32'd2);

        // Long enough to hit the right and bottom walls and come back.
        for (int f = 0; f < 150; f++) begin
            runFrame(1'b0);
            checkPosition("bounce");
        end
        checkOutput("bounce_dx_reversed", 32'(m_dx), 32'(-STEP));

        // Reset in the middle of a frame.
        pixel(200, 220);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 320 + i, 240, 1'b1, 1'b0);
        checkOutput("reset_rgb_zero", {20'h0, r, g, b}, 32'h0);
        applyStimulus(1'b0, 400, 240, 1'b1, 1'b0);
        checkPosition("pos_after_reset");

        auto_mode = 1'b1;
        for (int f = 0; f < 7; f++)
            runFrame(1'b0);
        checkOutput("auto_mode_after_7", {30'h0, mode_out}, 32'd2);
        runFrame(1'b0);
        runFrame(1'b1);
        checkOutput("auto_plus_manual", {30'h0, mode_out}, 32'd3);
        runFrame(1'b0);
        runFrame(1'b0);
        checkOutput("auto_restart_hold", {30'h0, mode_out}, 32'd3);
        runFrame(1'b0);
        checkOutput("auto_restart_adv", {30'h0, mode_out}, 32'd0);
        auto_mode = 1'b0;

        for (int i = 0; i < 3; i++)
            frameTick(1'b1);
        checkOutput("bars_mode", {30'h0, mode_out}, 32'd3);
        applyStimulus(1'b0, 79, 10, 1'b1, 1'b0);
        checkOutput("bar_sx79", {20'h0, r, g, b}, 32'hFFF);
        applyStimulus(1'b0, 80, 10, 1'b1, 1'b0);
        checkOutput("bar_sx80", {20'h0, r, g, b}, 32'hFF0);
        applyStimulus(1'b0, 639, 10, 1'b1, 1'b0);
        checkOutput("bar_sx639", {20'h0, r, g, b}, 32'h888);
        applyStimulus(1'b0, 640, 10, 1'b0, 1'b0);
        checkOutput("bar_sx640_blank", {20'h0, r, g, b}, 32'h0);
        for (int i = 0; i < 8; i++)
            pixel(int'($urandom_range(639, 0)), int'($urandom_range(479, 0)));

        // Mixed manual and auto requests over many frames.
        for (int f = 0; f < 60; f++) begin
            auto_mode = ($urandom_range(3, 0) == 0);
            runFrame($urandom_range(2, 0) == 0);
            if ($urandom_range(2, 0) == 0)
                applyStimulus(1'b0, int'($urandom_range(639, 1)), int'($urandom_range(479, 0)), 1'b1, 1'b1);
            checkPosition("soak");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
